bit_serializer: RTL

// Parallel-to-serial front end for the 1101 sequence detector. Accepts WIDTH-bit

---
 rtl/bit_serializer.sv | 115 +++++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial front end for the 1101 sequence detector. Takes
//   WIDTH-bit words on a valid/ready handshake and shifts them out one bit
//   per clock on x, with x_valid marking real data bits. A new word can be
//   taken on the last bit of the current one, so consecutive words stream
//   with no idle gap between them.
//
// Parameters
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   in_data     parallel word, sampled only when a word is accepted
//   in_valid    in_data is valid
//   in_ready    block can take a word this cycle (combinational)
//   x           serial bit to the detector
//   x_valid     x carries a real data bit this cycle
//   frame_done  high during the last bit of a word
//   busy        high while shifting a word out

module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic             last_bit;
  logic             accept;

  // The last bit of a word is also the slot where the next word may be
  // taken; that is what makes gap-free streaming possible.
  assign last_bit = (state == SHIFT) && (cnt == LAST);
  assign in_ready = !reset && ((state == IDLE) || last_bit);
  assign accept   = in_valid && in_ready;

  // All serial outputs come from registered state only. x is gated with the
  // state so the detector sees a clean 0 whenever nothing is being sent.
  assign busy       = (state == SHIFT);
  assign x_valid    = busy;
  assign frame_done = last_bit;
  assign x          = busy && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      shreg <= shreg_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shreg_next = shreg;
    case (state)
      IDLE: begin
        if (accept) begin
          shreg_next = in_data;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          if (accept) begin
            shreg_next = in_data;
            cnt_next   = '0;
          end else begin
            shreg_next = '0;
            cnt_next   = '0;
            state_next = IDLE;
          end
        end else begin
          // Move the next bit into the output position.
          cnt_next   = cnt + 1'b1;
          shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                 : {1'b0, shreg[WIDTH-1:1]};
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
